memory_read_ctrl: RTL and testbench

- Egress counterpart of memory_write_ctrl: accepts a packet descriptor (start block index + byte length), walks the block linked list in packet memory, and streams the payload out as a byte stream with begin/end markers.
- Returns each block to the free list once all its bytes have been emitted.
- Sits between the output queue/scheduler (descriptor source) and the egress MAC.
- Block geometry, ADDR_W, BLOCK_BITS, PAYLOAD_BYTES and footer_t come from mem_pkg.

---
 rtl/memory_read_ctrl.sv | 113 +++++++++++
 tb/tb_memory_read_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_read_ctrl.sv
// memory_read_ctrl: walks a packet's block chain and streams its payload out as bytes, releasing each block after use
package mem_pkg;
  localparam int ADDR_W = 8;
  localparam int PAYLOAD_BYTES = 8;
  typedef struct packed {
    logic [ADDR_W-1:0] next_idx;
    logic              eop;
    logic [6:0]        rsvd;
  } footer_t;
  localparam int FOOTER_BITS = $bits(footer_t);
  localparam int BLOCK_BITS = FOOTER_BITS + 8 * PAYLOAD_BYTES;
endpackage

module memory_read_ctrl
  import mem_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_valid_i,
  output logic                  pkt_ready_o,
  input  logic [ADDR_W-1:0]     pkt_start_addr_i,
  input  logic [LEN_W-1:0]      pkt_len_i,
  output logic                  mem_re_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  input  logic                  mem_rvalid_i,
  input  logic [BLOCK_BITS-1:0] mem_rdata_i,
  output logic [7:0]            data_o,
  output logic                  data_valid_o,
  output logic                  data_begin_o,
  output logic                  data_end_o,
  input  logic                  data_ready_i,
  output logic                  fl_free_req_o,
  output logic [ADDR_W-1:0]     fl_free_idx_o,
  input  logic                  fl_free_gnt_i,
  output logic                  err_o
);
  localparam int PB_W = $clog2(PAYLOAD_BYTES + 1);
  localparam int PI_W = $clog2(PAYLOAD_BYTES);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, STREAM, FREE} state_t;
  state_t state, state_d;
  logic [ADDR_W-1:0] cur_idx;
  logic [LEN_W-1:0] remaining, blk_full;
  logic first, err_q, accept, hs, last_in_blk, grant, err_d, unused_bits;
  logic [BLOCK_BITS-1:0] blk;
  logic [PAYLOAD_BYTES-1:0][7:0] payload;
  logic [PI_W-1:0] byte_ptr;
  logic [PB_W-1:0] blk_cnt;
  footer_t ft;
  assign ft = footer_t'(blk[FOOTER_BITS-1:0]);
  assign payload = blk[BLOCK_BITS-1:FOOTER_BITS];
  assign blk_full = remaining < LEN_W'(PAYLOAD_BYTES) ? remaining : LEN_W'(PAYLOAD_BYTES);
  assign unused_bits = ^{blk_full[LEN_W-1:PB_W], ft.rsvd};
  assign accept = state == IDLE && pkt_valid_i && pkt_len_i != '0;
  assign hs = state == STREAM && data_ready_i;
  assign last_in_blk = PB_W'(byte_ptr) == blk_cnt - PB_W'(1);
  assign grant = state == FREE && fl_free_gnt_i;
  assign err_d = (state == IDLE && pkt_valid_i && pkt_len_i == '0) || (grant && ((remaining == '0) != ft.eop));
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;
  // next-state: one read, a byte burst and one release per block
  always_comb
    state_d = state == IDLE    ? (accept ? RD_REQ : IDLE) :
              state == RD_REQ  ? RD_WAIT :
              state == RD_WAIT ? (mem_rvalid_i ? STREAM : RD_WAIT) :
              state == STREAM  ? (hs && last_in_blk ? FREE : STREAM) :
              grant            ? (remaining != '0 && !ft.eop ? RD_REQ : IDLE) : FREE;
  // packet walk state: current block, bytes left, block buffer and position within it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur_idx <= '0;
      remaining <= '0;
      first <= 1'b0;
      blk <= '0;
      byte_ptr <= '0;
      blk_cnt <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
      if (accept) begin
        cur_idx <= pkt_start_addr_i;
        remaining <= pkt_len_i;
        first <= 1'b1;
      end
      if (state == RD_WAIT && mem_rvalid_i) begin
        blk <= mem_rdata_i;
        byte_ptr <= '0;
        blk_cnt <= blk_full[PB_W-1:0];
      end
      if (hs) begin
        byte_ptr <= byte_ptr + PI_W'(1);
        remaining <= remaining - LEN_W'(1);
        first <= 1'b0;
      end
      if (grant && remaining != '0 && !ft.eop) cur_idx <= ft.next_idx;
    end
  // outputs decoded from state; everything reads zero outside its owning state
  always_comb begin
    pkt_ready_o = state == IDLE && !rst;
    mem_re_o = state == RD_REQ;
    mem_addr_o = state == RD_REQ ? cur_idx : '0;
    data_valid_o = state == STREAM;
    data_o = state == STREAM ? payload[byte_ptr] : '0;
    data_begin_o = state == STREAM && first;
    data_end_o = state == STREAM && remaining == LEN_W'(1);
    fl_free_req_o = state == FREE;
    fl_free_idx_o = state == FREE ? cur_idx : '0;
    err_o = err_q;
  end
endmodule

// File: tb/tb_memory_read_ctrl.sv
// tb_memory_read_ctrl: directed and randomized checks of memory_read_ctrl against a chain-walk reference model
module tb_memory_read_ctrl;
  import mem_pkg::*;
  localparam int P = PAYLOAD_BYTES;
  localparam int LEN_W = 16;
  logic clk, rst, pkt_valid_i, pkt_ready_o, mem_re_o, mem_rvalid_i;
  logic [ADDR_W-1:0] pkt_start_addr_i, mem_addr_o, fl_free_idx_o;
  logic [LEN_W-1:0] pkt_len_i;
  logic [BLOCK_BITS-1:0] mem_rdata_i;
  logic [7:0] data_o;
  logic data_valid_o, data_begin_o, data_end_o, data_ready_i;
  logic fl_free_req_o, fl_free_gnt_i, err_o;

  memory_read_ctrl #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .pkt_valid_i(pkt_valid_i), .pkt_ready_o(pkt_ready_o),
    .pkt_start_addr_i(pkt_start_addr_i), .pkt_len_i(pkt_len_i),
    .mem_re_o(mem_re_o), .mem_addr_o(mem_addr_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .data_o(data_o), .data_valid_o(data_valid_o),
    .data_begin_o(data_begin_o), .data_end_o(data_end_o),
    .data_ready_i(data_ready_i),
    .fl_free_req_o(fl_free_req_o), .fl_free_idx_o(fl_free_idx_o),
    .fl_free_gnt_i(fl_free_gnt_i), .err_o(err_o)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  logic [BLOCK_BITS-1:0] mem [256];
  int checks = 0, failures = 0;
  logic [9:0] obs_bytes[$], exp_bytes[$];
  logic [ADDR_W-1:0] obs_reads[$], exp_reads[$], obs_frees[$], exp_frees[$];
  int obs_err, exp_err;
  bit rdy_rand;
  int lat, gdelay, pend, gwait;
  logic [ADDR_W-1:0] pend_addr;
  bit prev_stall;
  logic [9:0] prev_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_blk(input int idx, input int nxt, input bit eop, input int base, input bit rnd);
    logic [BLOCK_BITS-1:0] b;
    footer_t f;
    b = '0;
    f.next_idx = ADDR_W'(nxt);
    f.eop = eop;
    f.rsvd = '0;
    b[FOOTER_BITS-1:0] = f;
    for (int k = 0; k < P; k++) b[FOOTER_BITS+8*k +: 8] = rnd ? 8'($urandom) : 8'(base + k);
    mem[idx] = b;
  endtask

  // reference: follow the chain, emit min(P, left) bytes per block, release each block, flag inconsistencies
  task automatic build_exp(input logic [ADDR_W-1:0] start, input int len);
    logic [BLOCK_BITS-1:0] b;
    footer_t f;
    int left, off, n;
    logic [ADDR_W-1:0] idx;
    exp_bytes.delete();
    exp_reads.delete();
    exp_frees.delete();
    exp_err = 0;
    if (len == 0) begin
      exp_err = 1;
      return;
    end
    idx = start;
    left = len;
    off = 0;
    for (int g = 0; g < 300; g++) begin
      exp_reads.push_back(idx);
      b = mem[idx];
      f = footer_t'(b[FOOTER_BITS-1:0]);
      n = left < P ? left : P;
      for (int k = 0; k < n; k++) begin
        exp_bytes.push_back({b[FOOTER_BITS+8*k +: 8], off == 0, off == len - 1});
        off++;
      end
      left -= n;
      exp_frees.push_back(idx);
      if (left == 0) begin
        exp_err = f.eop ? 0 : 1;
        break;
      end
      if (f.eop) begin
        exp_err = 1;
        break;
      end
      idx = f.next_idx;
    end
  endtask

  // environment: downstream sink, memory with fixed latency, free list with grant delay
  initial begin
    data_ready_i = 1;
    mem_rvalid_i = 0;
    mem_rdata_i = '0;
    fl_free_gnt_i = 0;
    forever begin
      @(negedge clk);
      if (err_o) obs_err++;
      if (prev_stall) check("stall_hold", {data_valid_o, data_o, data_begin_o, data_end_o}, {1'b1, prev_out});
      data_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (data_valid_o && data_ready_i) obs_bytes.push_back({data_o, data_begin_o, data_end_o});
      prev_stall = data_valid_o && !data_ready_i;
      prev_out = {data_o, data_begin_o, data_end_o};
      mem_rvalid_i = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_rvalid_i = 1;
          mem_rdata_i = mem[pend_addr];
        end
      end
      if (mem_re_o) begin
        obs_reads.push_back(mem_addr_o);
        pend = lat;
        pend_addr = mem_addr_o;
      end
      fl_free_gnt_i = 0;
      if (fl_free_req_o) begin
        if (gwait >= gdelay) begin
          fl_free_gnt_i = 1;
          obs_frees.push_back(fl_free_idx_o);
          gwait = 0;
        end else gwait++;
      end else gwait = 0;
    end
  end

  task automatic start_pkt(input string tag, input logic [ADDR_W-1:0] start, input int len);
    build_exp(start, len);
    obs_bytes.delete();
    obs_reads.delete();
    obs_frees.delete();
    obs_err = 0;
    @(negedge clk);
    check({tag, "_ready"}, 32'(pkt_ready_o), 1);
    pkt_valid_i = 1;
    pkt_start_addr_i = start;
    pkt_len_i = LEN_W'(len);
    @(negedge clk);
    pkt_valid_i = 0;
    check({tag, "_re_next"}, 32'(mem_re_o), 32'(len != 0));
    if (len != 0) check({tag, "_addr_next"}, 32'(mem_addr_o), 32'(start));
  endtask

  task automatic finish_pkt(input string tag);
    int n;
    n = 0;
    while (!pkt_ready_o && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_in_time"}, 32'(n < 3000), 1);
    repeat (3) @(negedge clk);
    check({tag, "_nbytes"}, obs_bytes.size(), exp_bytes.size());
    for (int i = 0; i < obs_bytes.size() && i < exp_bytes.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(obs_bytes[i]), 32'(exp_bytes[i]));
    check({tag, "_nreads"}, obs_reads.size(), exp_reads.size());
    for (int i = 0; i < obs_reads.size() && i < exp_reads.size(); i++)
      check($sformatf("%s_read%0d", tag, i), 32'(obs_reads[i]), 32'(exp_reads[i]));
    check({tag, "_nfrees"}, obs_frees.size(), exp_frees.size());
    for (int i = 0; i < obs_frees.size() && i < exp_frees.size(); i++)
      check($sformatf("%s_free%0d", tag, i), 32'(obs_frees[i]), 32'(exp_frees[i]));
    check({tag, "_err"}, obs_err, exp_err);
    check({tag, "_idle_ready"}, 32'(pkt_ready_o), 1);
  endtask

  task automatic run_pkt(input string tag, input logic [ADDR_W-1:0] start, input int len);
    start_pkt(tag, start, len);
    finish_pkt(tag);
  endtask

  initial begin
    int n, nb, len;
    int idx[4];
    rst = 1;
    pkt_valid_i = 0;
    pkt_start_addr_i = '0;
    pkt_len_i = '0;
    rdy_rand = 0;
    lat = 1;
    gdelay = 0;
    pend = 0;
    gwait = 0;
    prev_stall = 0;
    obs_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(pkt_ready_o), 0);
    check("rst_outs", {data_valid_o, data_begin_o, data_end_o, mem_re_o, fl_free_req_o, err_o}, 0);
    rst = 0;
    #1 check("rst_release_ready", 32'(pkt_ready_o), 1);

    for (int b = 0; b < 4; b++) set_blk(b, b + 1, b == 3, b * P, 0);
    run_pkt("chain4", 0, 4 * P);
    set_blk(5, 0, 1, 0, 0);
    run_pkt("single", 5, 1);
    set_blk(7, 9, 0, 0, 0);
    set_blk(9, 0, 1, P, 0);
    run_pkt("two_blk", 7, P + 3);
    set_blk(30, 31, 1, 0, 0);
    run_pkt("early_eop", 30, 2 * P);
    set_blk(40, 41, 0, 0, 0);
    run_pkt("missing_eop", 40, P);
    run_pkt("zero_len", 5, 0);

    rdy_rand = 1;
    lat = 3;
    gdelay = 2;
    run_pkt("chain4_stall", 0, 4 * P);
    for (int t = 0; t < 3; t++) begin
      nb = $urandom_range(1, 4);
      for (int i = 0; i < nb; i++) idx[i] = 100 + 30 * i + $urandom_range(0, 29);
      for (int i = 0; i < nb; i++) set_blk(idx[i], i < nb - 1 ? idx[i+1] : 0, i == nb - 1, 0, 1);
      len = $urandom_range((nb - 1) * P + 1, nb * P);
      run_pkt($sformatf("rand%0d", t), ADDR_W'(idx[0]), len);
    end

    rdy_rand = 0;
    lat = 1;
    gdelay = 0;
    start_pkt("rst_mid", 0, 4 * P);
    n = 0;
    while (obs_bytes.size() < 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reached_stream", 32'(n < 500), 1);
    #2 rst = 1;
    pend = 0;
    gwait = 0;
    prev_stall = 0;
    #1;
    check("rst_mid_outs", {pkt_ready_o, data_valid_o, data_begin_o, data_end_o, mem_re_o, fl_free_req_o, err_o}, 0);
    check("rst_mid_buses", {data_o, mem_addr_o, fl_free_idx_o}, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    run_pkt("after_rst", 7, P + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
